// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a NUM_DIGITS 7-segment display with frame-synchronous
// value updates, leading-zero blanking, decimal points and selectable pin polarity.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_DIV      = 25000,
    parameter bit ACTIVE_LOW_SEG = 1'b0,
    parameter bit ACTIVE_LOW_DIG = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic [NUM_DIGITS-1:0]   i_Dp,
    input  logic                    i_Load,
    output logic [6:0]              o_Segments,
    output logic                    o_Seg_DP,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Frame_Done,
    output logic                    o_Load_Pending
);

    localparam int P_W = $clog2(DIGIT_DIV);
    localparam int D_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [P_W-1:0] P_LAST = P_W'(DIGIT_DIV - 1);
    localparam logic [D_W-1:0] D_LAST = D_W'(NUM_DIGITS - 1);

    // Slot timer counts down: P_LAST marks the first cycle of a slot, 0 the last.
    logic [P_W-1:0]          r_presc_cnt;
    logic [D_W-1:0]          r_digit;
    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_flag;

    logic                    w_slot_first;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_visible;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic                    w_vis_bit;

    function automatic logic [6:0] encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    // A digit stays lit if it or any more significant digit carries a nonzero nibble or a DP.
    function automatic logic [NUM_DIGITS-1:0] visible_mask(
        input logic [4*NUM_DIGITS-1:0] val,
        input logic [NUM_DIGITS-1:0]   dp
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  any_set;
        mask    = '0;
        any_set = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            any_set = any_set | (|val[4*k +: 4]) | dp[k];
            mask[k] = any_set | (k == 0) | ~BLANK_LEADING;
        end
        return mask;
    endfunction

    assign w_slot_first = (r_presc_cnt == P_LAST);
    assign w_slot_end   = (r_presc_cnt == '0);
    assign w_frame_end  = w_slot_end && (r_digit == D_LAST);
    assign w_visible    = visible_mask(r_shadow_val, r_shadow_dp);

    always_comb begin
        w_nibble  = 4'h0;
        w_dp_bit  = 1'b0;
        w_vis_bit = 1'b0;
        w_onehot  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_digit == D_W'(k)) begin
                w_nibble    = r_shadow_val[4*k +: 4];
                w_dp_bit    = r_shadow_dp[k];
                w_vis_bit   = w_visible[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_presc_cnt  <= P_LAST;
            r_digit      <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_flag  <= 1'b0;
            o_Segments   <= {7{ACTIVE_LOW_SEG}};
            o_Seg_DP     <= ACTIVE_LOW_SEG;
            o_Digit_En   <= {NUM_DIGITS{ACTIVE_LOW_DIG}};
            o_Frame_Done <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_presc_cnt <= P_LAST;
                r_digit     <= (r_digit == D_LAST) ? '0 : r_digit + 1'b1;
            end else begin
                r_presc_cnt <= r_presc_cnt - 1'b1;
            end

            // A load landing on the frame-end edge bypasses and discards any pending value.
            if (w_frame_end) begin
                if (i_Load) begin
                    r_shadow_val <= i_Value;
                    r_shadow_dp  <= i_Dp;
                end else if (r_pend_flag) begin
                    r_shadow_val <= r_pend_val;
                    r_shadow_dp  <= r_pend_dp;
                end
                r_pend_flag <= 1'b0;
            end else if (i_Load) begin
                r_pend_val  <= i_Value;
                r_pend_dp   <= i_Dp;
                r_pend_flag <= 1'b1;
            end

            o_Frame_Done <= w_frame_end;
            o_Segments   <= (w_vis_bit ? encode(w_nibble) : 7'h00) ^ {7{ACTIVE_LOW_SEG}};
            o_Seg_DP     <= (w_vis_bit & w_dp_bit) ^ ACTIVE_LOW_SEG;
            o_Digit_En   <= ((!w_slot_first && w_vis_bit) ? w_onehot : '0)
                            ^ {NUM_DIGITS{ACTIVE_LOW_DIG}};
        end
    end

    assign o_Load_Pending = r_pend_flag;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: literal vector table, hand-written corner sequences, and
// randomized loads checked every cycle against a frame-arithmetic reference model.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;
    localparam bit ALS   = 1'b0;
    localparam bit ALD   = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic [6:0]  seg;
    logic        sdp;
    logic [3:0]  en;
    logic        fd;
    logic        lp;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS    (N),
        .DIGIT_DIV     (DIV),
        .ACTIVE_LOW_SEG(ALS),
        .ACTIVE_LOW_DIG(ALD),
        .BLANK_LEADING (1'b1)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Value       (value),
        .i_Dp          (dp),
        .i_Load        (load),
        .o_Segments    (seg),
        .o_Seg_DP      (sdp),
        .o_Digit_En    (en),
        .o_Frame_Done  (fd),
        .o_Load_Pending(lp)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position comes from a cycle count since reset release.
    int          cnt;
    logic [15:0] m_shadow, m_pend_val;
    logic [3:0]  m_shadow_dp, m_pend_dp;
    bit          m_pend;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_en;
    logic        e_fd, e_lp;
    logic [6:0]  enc_tab [16];

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpv;
        logic [3:0][6:0] segs;
        logic [3:0]      vis;
    } vec_t;
    vec_t vec [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit m_visible(input int k);
        int top = 0;
        for (int j = 0; j < N; j++)
            if (m_shadow[4*j +: 4] != 4'h0 || m_shadow_dp[j]) top = j;
        return k <= top;
    endfunction

    task automatic model_reset();
        cnt = 0; m_shadow = '0; m_shadow_dp = '0;
        m_pend_val = '0; m_pend_dp = '0; m_pend = 1'b0;
    endtask

    task automatic model_step();
        int p = cnt % DIV;
        int d = (cnt / DIV) % N;
        bit fe = (cnt % FRAME) == FRAME - 1;
        bit vis = m_visible(d);
        logic [3:0] oh;
        oh    = 4'(1 << d);
        e_seg = (vis ? enc_tab[m_shadow[4*d +: 4]] : 7'h00) ^ {7{ALS}};
        e_dp  = (vis & m_shadow_dp[d]) ^ ALS;
        e_en  = ((p != 0 && vis) ? oh : 4'h0) ^ {4{ALD}};
        e_fd  = fe;
        if (fe) begin
            if (load) begin
                m_shadow = value; m_shadow_dp = dp;
            end else if (m_pend) begin
                m_shadow = m_pend_val; m_shadow_dp = m_pend_dp;
            end
            m_pend = 1'b0;
        end else if (load) begin
            m_pend_val = value; m_pend_dp = dp; m_pend = 1'b1;
        end
        e_lp = m_pend;
        cnt++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("m_seg", seg, e_seg);
        chk("m_dp", sdp, e_dp);
        chk("m_en", en, e_en);
        chk("m_fd", fd, e_fd);
        chk("m_lp", lp, e_lp);
    endtask

    task automatic go_frame_start();
        while (cnt % FRAME != 0) tick();
    endtask

    task automatic apply_load(input logic [15:0] v, input logic [3:0] d);
        if (cnt % FRAME == FRAME - 1) tick();
        value = v; dp = d; load = 1'b1;
        tick();
        load = 1'b0;
        go_frame_start();
    endtask

    task automatic check_frame_const(input string name, input logic [6:0] exp_seg);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            chk(name, seg, exp_seg);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_en;
        enc_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        vec[0] = '{16'h1A3F, 4'h0, {7'h30, 7'h77, 7'h79, 7'h47}, 4'hF};
        vec[1] = '{16'h0050, 4'h8, {7'h7E, 7'h7E, 7'h5B, 7'h7E}, 4'hF};
        vec[2] = '{16'h0005, 4'h0, {7'h7E, 7'h7E, 7'h7E, 7'h5B}, 4'h1};
        vec[3] = '{16'h0000, 4'h0, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'h1};
        vec[4] = '{16'h8421, 4'h5, {7'h7F, 7'h33, 7'h6D, 7'h30}, 4'hF};
        vec[5] = '{16'h00C0, 4'h0, {7'h7E, 7'h7E, 7'h4E, 7'h7E}, 4'h3};
        vec[6] = '{16'hBEEF, 4'hF, {7'h1F, 7'h4F, 7'h4F, 7'h47}, 4'hF};
        vec[7] = '{16'h0600, 4'h2, {7'h7E, 7'h5F, 7'h7E, 7'h7E}, 4'h7};
        vec[8] = '{16'h7D09, 4'h0, {7'h70, 7'h3D, 7'h7E, 7'h7B}, 4'hF};
        vec[9] = '{16'h0000, 4'h1, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'h1};

        rst_n = 1'b0; load = 1'b0; value = '0; dp = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 7'h00);
        chk("rst_dp", sdp, 1'b0);
        chk("rst_en", en, 4'hF);
        chk("rst_fd", fd, 1'b0);
        chk("rst_lp", lp, 1'b0);
        rst_n = 1'b1;

        // Frame-done spacing and first pulse position after release
        for (int t = 1; t <= 3 * FRAME; t++) begin
            tick();
            chk("fd_period", fd, (t % FRAME) == 0);
        end

        // Vector table: literal per-slot expectations over one full frame
        for (int i = 0; i < 10; i++) begin
            apply_load(vec[i].val, vec[i].dpv);
            for (int d = 0; d < N; d++) begin
                for (int q = 0; q < DIV; q++) begin
                    tick();
                    exp_en = (q != 0 && vec[i].vis[d]) ? ~(4'(1 << d)) : 4'hF;
                    chk("tbl_seg", seg, vec[i].vis[d] ? vec[i].segs[d] : 7'h00);
                    chk("tbl_dp", sdp, vec[i].vis[d] & vec[i].dpv[d]);
                    chk("tbl_en", en, exp_en);
                end
            end
        end

        // Tear-free: two loads mid-frame, last one wins, current frame unchanged
        apply_load(16'h3333, 4'h0);
        repeat (3) tick();
        value = 16'h1111; load = 1'b1; tick();
        load = 1'b0; tick();
        value = 16'h2222; load = 1'b1; tick();
        load = 1'b0;
        chk("tear_lp", lp, 1'b1);
        while (cnt % FRAME != 0) begin
            tick();
            chk("tear_cur", seg, 7'h79);
        end
        chk("tear_lp_clr", lp, 1'b0);
        check_frame_const("tear_next", 7'h6D);

        // Load on the frame-end edge overrides a pending value
        repeat (2) tick();
        value = 16'h4444; load = 1'b1; tick();
        load = 1'b0;
        while (cnt % FRAME != FRAME - 1) tick();
        chk("fe_lp_set", lp, 1'b1);
        value = 16'h9999; load = 1'b1; tick();
        load = 1'b0;
        chk("fe_lp_clr", lp, 1'b0);
        chk("fe_fd", fd, 1'b1);
        check_frame_const("fe_next", 7'h7B);

        // Async reset mid-slot (p=2, d=2) with a pending load
        repeat (2) tick();
        value = 16'h7777; load = 1'b1; tick();
        load = 1'b0;
        while (cnt % FRAME != 2 * DIV + 2) tick();
        chk("ar_lp_before", lp, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("ar_seg", seg, 7'h00);
        chk("ar_dp", sdp, 1'b0);
        chk("ar_en", en, 4'hF);
        chk("ar_fd", fd, 1'b0);
        chk("ar_lp", lp, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int q = 0; q < DIV; q++) begin
            tick();
            exp_en = (q == 0) ? 4'hF : 4'hE;
            chk("ar_restart_en", en, exp_en);
            chk("ar_restart_seg", seg, 7'h7E);
        end
        for (int q = 0; q < DIV; q++) begin
            tick();
            chk("ar_blank_en", en, 4'hF);
        end

        // Randomized loads, including loads landing on frame-end edges
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 9) == 0) ||
                   ((cnt % FRAME == FRAME - 1) && ($urandom_range(0, 2) == 0));
            if (load) begin
                for (int k = 0; k < N; k++)
                    value[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                for (int k = 0; k < N; k++)
                    dp[k] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
